// File: rtl/sram_stream_reader_if.sv
// Bundle of command, SRAM-port and output-stream signals for the SRAM stream reader.
// master: the reader itself (drives SRAM controls, status and stream data).
// slave: the environment (command source, SRAM data return, stream sink).
interface sram_stream_reader_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  // command / status
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  // SRAM port
  logic          csb;
  logic          wsb;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  // output stream
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    input  start, base_addr, len, rdata, m_ready,
    output busy, done, csb, wsb, raddr, m_data, m_valid
  );

  modport slave (
    output start, base_addr, len, rdata, m_ready,
    input  busy, done, csb, wsb, raddr, m_data, m_valid
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Reads LEN consecutive SRAM words from BASE (wrapping at DEPTH) and streams them out valid/ready.
// Latency: start seen at edge T, read issued in the next cycle, first m_valid in the cycle after that.
// Backpressure: m_ready low holds m_data; reads are throttled so FIFO words plus the in-flight read never exceed 2.
module sram_stream_reader #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  sram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [AW-1:0] raddr_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q, count_d;

  logic [1:0]    occupancy;
  logic          bypass;
  logic          stream_vld;
  logic          pop;
  logic          push;
  logic          fifo_pop;
  logic          issue;
  logic          last_issue;
  logic          last_pop;

  // Credit, FIFO and address bookkeeping. When the FIFO is empty the word returning from the
  // SRAM is shown directly (rdata is already registered inside the SRAM) so a steady stream
  // runs at one word per cycle with only one read outstanding.
  always_comb begin
    occupancy   = count_q + {1'b0, inflight_q};
    bypass      = (count_q == 2'd0) && inflight_q;
    stream_vld  = (count_q != 2'd0) || inflight_q;
    pop         = stream_vld && bus.m_ready;
    push        = inflight_q && !(bypass && pop);
    fifo_pop    = pop && !bypass;
    issue       = (state_q == READ) && (occupancy < 2'd2);
    last_issue  = issue && (remaining_q == (AW+1)'(1));
    last_pop    = pop && (occupancy == 2'd1);

    count_d = count_q;
    case ({push, fifo_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (state_q == IDLE && bus.start) begin
      cur_addr_d  = bus.base_addr;
      remaining_d = bus.len;
    end else if (issue) begin
      cur_addr_d  = (cur_addr_q == AW'(DEPTH - 1)) ? '0 : cur_addr_q + AW'(1);
      remaining_d = remaining_q - (AW+1)'(1);
    end
  end

  // Control FSM with registered busy/done; start is only looked at while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      done_q      <= 1'b0;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In-flight flag, last issued address and the 2-entry output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      raddr_q    <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= issue;
      if (issue) raddr_q <= cur_addr_q;
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign bus.csb     = ~issue;
  assign bus.wsb     = 1'b1;
  assign bus.raddr   = issue ? cur_addr_q : raddr_q;
  assign bus.m_valid = stream_vld;
  assign bus.m_data  = bypass ? bus.rdata : fifo_q[rd_ptr_q];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, scoreboard queues for addresses and data,
// a table of read operations plus hand-written abort and start-while-busy sequences.
module tb_sram_stream_reader;
  logic clk;
  logic rst;

  sram_stream_reader_if #(.DW(8), .AW(5)) bus ();

  sram_stream_reader #(.DW(8), .AW(5), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] mem [32];
  logic [7:0] exp_q [$];
  logic [4:0] addr_q [$];

  int         cyc = 0;
  int         issued = 0;
  int         accepted = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         words_got = 0;
  int         issue_cnt = 0;
  int         first_valid_cyc = -1;
  logic [4:0] last_addr = '0;
  bit         busy_seen = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  typedef struct {
    logic [4:0]  base;
    logic [5:0]  len;
    logic [15:0] rdy;
    int          words;
    logic [4:0]  last;
    int          first_lat;
    int          done_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: registered read, one cycle after a cycle with csb low.
  initial begin
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      if (!bus.csb) bus.rdata <= mem[bus.raddr];
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    logic [7:0] exp_d;
    logic [4:0] exp_a;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        issued     = 0;
        accepted   = 0;
        prev_stall = 1'b0;
      end else begin
        if (bus.busy) busy_seen = 1'b1;
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (!bus.csb) begin
          check("credit_fifo_plus_inflight_below_2", longint'((issued - accepted) < 2), 1);
          check("issue_expected", longint'(addr_q.size() != 0), 1);
          if (addr_q.size() != 0) begin
            exp_a = addr_q.pop_front();
            check("raddr", bus.raddr, exp_a);
          end
          issue_cnt++;
          last_addr = bus.raddr;
          issued++;
        end
        if (prev_stall) begin
          check("stall_valid_hold", bus.m_valid, 1);
          check("stall_data_hold", bus.m_data, prev_data);
        end
        if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.m_valid && bus.m_ready) begin
          check("word_expected", longint'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            check("m_data", bus.m_data, exp_d);
          end
          words_got++;
          accepted++;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
      end
    end
  end

  task automatic clear_op_stats();
    done_cnt        = 0;
    done_cyc        = 0;
    words_got       = 0;
    issue_cnt       = 0;
    first_valid_cyc = -1;
    busy_seen       = 1'b0;
  endtask

  task automatic push_expected(input logic [4:0] base, input logic [5:0] len);
    logic [4:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 5'(i);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
  endtask

  // One read operation: pushes expectations, pulses start, drives the ready pattern until done.
  task automatic run_op(input logic [4:0] base, input logic [5:0] len, input logic [15:0] pat,
                        input int exp_words, input logic [4:0] exp_last,
                        input int exp_first, input int exp_done, input int dup_at);
    int k;
    int start_c;
    @(posedge clk); #1;
    push_expected(base, len);
    clear_op_stats();
    bus.base_addr = base;
    bus.len       = len;
    bus.start     = 1'b1;
    bus.m_ready   = pat[0];
    start_c       = cyc + 1;
    k = 0;
    while (done_cnt == 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
      bus.start = (k == dup_at);
      if (k == dup_at) begin
        bus.base_addr = 5'd0;
        bus.len       = 6'd2;
      end
      bus.m_ready = pat[k % 16];
    end
    bus.start   = 1'b0;
    bus.m_ready = 1'b1;
    check("done_before_timeout", longint'(done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (exp_first >= 0) check("first_valid_latency", first_valid_cyc - start_c, exp_first);
    if (exp_done >= 0) check("done_latency", done_cyc - start_c, exp_done);
    check("done_pulses", done_cnt, 1);
    check("words_delivered", words_got, exp_words);
    check("scoreboard_empty", exp_q.size(), 0);
    check("issue_count", issue_cnt, len);
    if (len != 6'd0) check("last_raddr", last_addr, exp_last);
    check("busy_after", bus.busy, 0);
    check("busy_seen", busy_seen, longint'(len != 6'd0));
    check("wsb", bus.wsb, 1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 8'h10);

    vecs[0] = '{5'd0,  6'd4,  16'hFFFF, 4,  5'd3,  2, 6};
    vecs[1] = '{5'd30, 6'd4,  16'hFFFF, 4,  5'd1,  2, 6};
    vecs[2] = '{5'd0,  6'd8,  16'hBAE9, 8,  5'd7,  2, -1};
    vecs[3] = '{5'd0,  6'd0,  16'hFFFF, 0,  5'd0, -1, 1};
    vecs[4] = '{5'd5,  6'd32, 16'hFFFF, 32, 5'd4,  2, 34};
    vecs[5] = '{5'd20, 6'd6,  16'h5555, 6,  5'd25, 2, -1};
    vecs[6] = '{5'd31, 6'd3,  16'h0F0F, 3,  5'd1,  2, -1};
    vecs[7] = '{5'd10, 6'd1,  16'hFFFF, 1,  5'd10, 2, 3};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.m_ready   = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_csb", bus.csb, 1);
    check("rst_wsb", bus.wsb, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_raddr", bus.raddr, 0);
    check("rst_m_data", bus.m_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run_op(vecs[v].base, vecs[v].len, vecs[v].rdy, vecs[v].words, vecs[v].last,
             vecs[v].first_lat, vecs[v].done_lat, -1);

    // abort: reset after the third word of a 10-word read
    @(posedge clk); #1;
    push_expected(5'd0, 6'd10);
    clear_op_stats();
    bus.base_addr = 5'd0;
    bus.len       = 6'd10;
    bus.start     = 1'b1;
    bus.m_ready   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (words_got < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reached_word3", longint'(words_got >= 3), 1);
    rst         = 1'b1;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_csb", bus.csb, 1);
    check("abort_done", bus.done, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_m_valid", bus.m_valid, 0);
    exp_q.delete();
    addr_q.delete();

    // fresh start after abort, with backpressure
    run_op(5'd3, 6'd5, 16'h3333, 5, 5'd7, 2, -1, -1);
    // start while busy must be ignored
    run_op(5'd12, 6'd6, 16'hFFFF, 6, 5'd17, 2, 8, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d miscompares so far", err_cnt);
    $fatal(1, "watchdog");
  end
endmodule
